// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-space target: FSM states, bus level
// constants and the address-match helper.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] target);
    return addr_byte[7:1] == target;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus stability filter for one open-drain bus line; emits the
// filtered level and single-cycle rise/fall pulses aligned with level changes.
module i2c_line_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 3
) (
  input  logic ICE_CLK,
  input  logic ICE_RST,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(GLITCH_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // The level only flips once the synchronised input has disagreed with it for
  // GLITCH_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din};
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (synced != level_q) begin
      if (cnt_q == CW'(GLITCH_CYCLES - 1)) begin
        level_d = synced;
        rise_d  = synced;
        fall_d  = ~synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments, and the reset is sampled
  // on the clock edge so idle-high bus levels are restored without async paths.
  always_ff @(posedge ICE_CLK) begin
    if (ICE_RST) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a 256-byte register space through a strobe interface;
// SDA is driven low via sda_oe only, SCL is never stretched.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR      = 7'h42,
  parameter int         SYNC_STAGES   = 2,
  parameter int         GLITCH_CYCLES = 3
) (
  input  logic       ICE_CLK,
  input  logic       ICE_RST,
  input  logic       scl_di,
  input  logic       sda_di,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_scl_filter (
    .ICE_CLK(ICE_CLK), .ICE_RST(ICE_RST), .din(scl_di),
    .level(scl_f), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_sda_filter (
    .ICE_CLK(ICE_CLK), .ICE_RST(ICE_RST), .din(sda_di),
    .level(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shifter_q, shifter_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       rw_q, rw_d;
  logic       ack_ok_q, ack_ok_d;
  logic       sda_oe_q, sda_oe_d;
  logic       reg_we_q, reg_we_d;
  logic       busy_q, busy_d;
  logic       start_cond, stop_cond, rd_load;

  assign start_cond = sda_fall & scl_f;
  assign stop_cond  = sda_rise & scl_f;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shifter_d   = shifter_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    rw_d        = rw_q;
    ack_ok_d    = ack_ok_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    reg_we_d    = 1'b0;
    rd_load     = 1'b0;

    if (reg_we_q) reg_addr_d = reg_addr_q + 8'd1;

    if (start_cond || stop_cond) begin
      state_d   = start_cond ? ST_ADDR : ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          shifter_d = {shifter_q[6:0], sda_f};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (state_q == ST_WDATA && bit_cnt_q == BITS_PER_BYTE - 4'd1) begin
            reg_we_d    = 1'b1;
            reg_wdata_d = {shifter_q[6:0], sda_f};
          end
        end
        ST_RDATA: bit_cnt_d = bit_cnt_q + 4'd1;
        ST_RDATA_ACK: begin
          ack_ok_d = (sda_f == I2C_ACK);
          if (sda_f == I2C_ACK) reg_addr_d = reg_addr_q + 8'd1;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR: if (bit_cnt_q == BITS_PER_BYTE) begin
          bit_cnt_d = '0;
          if (addr_match(shifter_q, I2C_ADDR)) begin
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            rw_d     = shifter_q[0];
            state_d  = ST_ADDR_ACK;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        ST_ADDR_ACK: begin
          if (rw_q == I2C_RW_READ) begin
            rd_load = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_PTR;
          end
        end
        ST_PTR: if (bit_cnt_q == BITS_PER_BYTE) begin
          reg_addr_d = shifter_q;
          bit_cnt_d  = '0;
          sda_oe_d   = 1'b1;
          state_d    = ST_PTR_ACK;
        end
        ST_WDATA: if (bit_cnt_q == BITS_PER_BYTE) begin
          bit_cnt_d = '0;
          sda_oe_d  = 1'b1;
          state_d   = ST_WDATA_ACK;
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          sda_oe_d = 1'b0;
          state_d  = ST_WDATA;
        end
        ST_RDATA: begin
          if (bit_cnt_q == BITS_PER_BYTE) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            state_d   = ST_RDATA_ACK;
          end else begin
            shifter_d = {shifter_q[6:0], 1'b0};
            sda_oe_d  = ~shifter_q[6];
          end
        end
        ST_RDATA_ACK: begin
          if (ack_ok_q) begin
            rd_load = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_IGNORE;
          end
        end
        default: ;
      endcase
    end

    // Read data is taken from the bank in the same cycle reg_re is high, and
    // its MSB goes onto the bus on the next edge.
    if (rd_load) begin
      shifter_d = reg_rdata;
      sda_oe_d  = ~reg_rdata[7];
      bit_cnt_d = '0;
      state_d   = ST_RDATA;
    end
  end

  always_ff @(posedge ICE_CLK) begin
    if (ICE_RST) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shifter_q   <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      rw_q        <= I2C_RW_WRITE;
      ack_ok_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shifter_q   <= shifter_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      rw_q        <= rw_d;
      ack_ok_q    <= ack_ok_d;
      sda_oe_q    <= sda_oe_d;
      reg_we_q    <= reg_we_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = rd_load & ~ICE_RST;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: an open-drain bus master plus a transaction-level
// model of the register target, with a per-cycle strobe scoreboard.
module tb_i2c_target_regs;

  localparam logic [6:0] TGT    = 7'h42;
  localparam int         W_LOW  = 20;
  localparam int         HALF   = 10;
  localparam int         HOLD   = 4;

  typedef enum {P_IDLE, P_ADDR, P_PTR, P_WDATA, P_RDATA, P_IGNORE} phase_t;

  logic       ICE_CLK = 1'b0;
  logic       ICE_RST = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1, scl_glitch = 1'b0;
  logic       scl_di, sda_di, sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  int n_checks = 0;
  int n_errors = 0;

  phase_t      phase = P_IDLE;
  logic [7:0]  model_ptr = 8'h00;
  logic        model_busy = 1'b0;
  logic [15:0] we_q[$];
  logic [7:0]  re_q[$];
  logic        scl_prev = 1'b1, oe_prev = 1'b0;

  assign scl_di    = scl_m & ~scl_glitch;
  assign sda_di    = sda_m & ~sda_oe;
  assign reg_rdata = reg_addr ^ 8'hFF;

  always #5 ICE_CLK = ~ICE_CLK;

  i2c_target_regs #(.I2C_ADDR(TGT), .SYNC_STAGES(2), .GLITCH_CYCLES(3)) dut (
    .ICE_CLK(ICE_CLK), .ICE_RST(ICE_RST),
    .scl_di(scl_di), .sda_di(sda_di), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge ICE_CLK);
  endtask

  // Strobe scoreboard and "SDA steady while SCL high" rule, every cycle.
  always @(negedge ICE_CLK) begin
    logic [15:0] exp_we;
    logic [7:0]  exp_re;
    if (!ICE_RST) begin
      if (reg_we) begin
        check("we_expected", 32'(we_q.size() != 0), 32'd1);
        if (we_q.size() != 0) begin
          exp_we = we_q.pop_front();
          check("we_addr_data", {reg_addr, reg_wdata}, exp_we);
        end
      end
      if (reg_re) begin
        check("re_expected", 32'(re_q.size() != 0), 32'd1);
        if (re_q.size() != 0) begin
          exp_re = re_q.pop_front();
          check("re_addr", reg_addr, exp_re);
        end
      end
      if (scl_m && scl_prev) check("sda_oe_steady_scl_high", sda_oe, oe_prev);
    end
    scl_prev = scl_m;
    oe_prev  = sda_oe;
  end

  task automatic clock_bit(input logic b, input int glen, output logic r);
    sda_m = b;
    wait_cyc(W_LOW);
    scl_m = 1'b1;
    wait_cyc(5);
    if (glen > 0) begin
      scl_glitch = 1'b1;
      wait_cyc(glen);
      scl_glitch = 1'b0;
    end
    wait_cyc(HALF - 5 - glen);
    r = sda_di;
    check("busy", busy, model_busy);
    wait_cyc(HALF);
    scl_m = 1'b0;
    wait_cyc(HOLD);
  endtask

  task automatic start_cond();
    sda_m = 1'b1;
    wait_cyc(W_LOW);
    scl_m = 1'b1;
    wait_cyc(W_LOW);
    sda_m = 1'b0;
    wait_cyc(W_LOW);
    scl_m = 1'b0;
    wait_cyc(HOLD);
    phase      = P_ADDR;
    model_busy = 1'b0;
  endtask

  task automatic stop_cond();
    sda_m = 1'b0;
    wait_cyc(W_LOW);
    scl_m = 1'b1;
    wait_cyc(W_LOW);
    sda_m = 1'b1;
    wait_cyc(W_LOW);
    phase      = P_IDLE;
    model_busy = 1'b0;
    check("busy_after_stop", busy, 1'b0);
  endtask

  // Model effects are booked before the byte is clocked, since the target's
  // strobes fire within the byte / ACK clock.
  task automatic write_byte(input logic [7:0] b, input int gbit, input int glen, output logic ack);
    logic exp_ack, next_busy, r;
    exp_ack   = 1'b1;
    next_busy = model_busy;
    case (phase)
      P_ADDR: begin
        if (b[7:1] == TGT) begin
          exp_ack   = 1'b0;
          next_busy = 1'b1;
          if (b[0]) begin
            phase = P_RDATA;
            re_q.push_back(model_ptr);
          end else begin
            phase = P_PTR;
          end
        end else begin
          phase = P_IGNORE;
        end
      end
      P_PTR: begin
        exp_ack   = 1'b0;
        model_ptr = b;
        phase     = P_WDATA;
      end
      P_WDATA: begin
        exp_ack = 1'b0;
        we_q.push_back({model_ptr, b});
        model_ptr = model_ptr + 8'd1;
      end
      default: ;
    endcase
    for (int i = 7; i >= 0; i--) clock_bit(b[i], ((7 - i) == gbit) ? glen : 0, r);
    model_busy = next_busy;
    clock_bit(1'b1, 0, ack);
    check("target_ack", ack, exp_ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] data);
    logic [7:0] exp;
    logic       r;
    exp  = model_ptr ^ 8'hFF;
    data = '0;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, 0, r);
      data = {data[6:0], r};
    end
    check("read_data", data, exp);
    if (mack == 1'b0) begin
      model_ptr = model_ptr + 8'd1;
      re_q.push_back(model_ptr);
    end else begin
      phase = P_IGNORE;
    end
    clock_bit(mack, 0, r);
  endtask

  task automatic check_drained(input string name);
    check({name, "_we_pending"}, we_q.size(), 0);
    check({name, "_re_pending"}, re_q.size(), 0);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;

    wait_cyc(4);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_reg_we", reg_we, 1'b0);
    check("rst_reg_re", reg_re, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    ICE_RST = 1'b0;
    wait_cyc(10);

    // Pointer write then two data bytes with auto-increment.
    start_cond();
    write_byte(8'h84, -1, 0, ack); check("wr_addr_ack_lit", ack, 1'b0);
    write_byte(8'h10, -1, 0, ack); check("wr_ptr_ack_lit", ack, 1'b0);
    write_byte(8'hA5, -1, 0, ack); check("wr_d0_ack_lit", ack, 1'b0);
    write_byte(8'h5A, -1, 0, ack); check("wr_d1_ack_lit", ack, 1'b0);
    stop_cond();
    check("wr_final_addr_lit", reg_addr, 8'h12);
    check_drained("wr");

    // Pointer write, repeated START, read ACK then NACK.
    start_cond();
    write_byte(8'h84, -1, 0, ack);
    write_byte(8'h20, -1, 0, ack);
    start_cond();
    write_byte(8'h85, -1, 0, ack);
    read_byte(1'b0, d); check("rd0_lit", d, 8'hDF);
    read_byte(1'b1, d); check("rd1_lit", d, 8'hDE);
    wait_cyc(10);
    check("rd_released_after_nack", sda_oe, 1'b0);
    stop_cond();
    check_drained("rd");

    // Foreign address: never acknowledged, no strobes, never busy.
    start_cond();
    write_byte(8'h86, -1, 0, ack); check("foreign_addr_nack_lit", ack, 1'b1);
    write_byte(8'h11, -1, 0, ack);
    write_byte(8'h22, -1, 0, ack); check("foreign_data_nack_lit", ack, 1'b1);
    stop_cond();
    check_drained("foreign");

    // Short SCL low glitches inside data bytes must not add clock edges.
    start_cond();
    write_byte(8'h84, -1, 0, ack);
    write_byte(8'h30, -1, 0, ack);
    write_byte(8'hC3, 3, 1, ack);
    write_byte(8'h3C, 5, 2, ack);
    stop_cond();
    check("glitch_final_addr_lit", reg_addr, 8'h32);
    check_drained("glitch");

    // Read across the 0xFF -> 0x00 pointer wrap.
    start_cond();
    write_byte(8'h84, -1, 0, ack);
    write_byte(8'hFF, -1, 0, ack);
    start_cond();
    write_byte(8'h85, -1, 0, ack);
    read_byte(1'b0, d); check("wrap_rd0_lit", d, 8'h00);
    read_byte(1'b0, d); check("wrap_rd1_lit", d, 8'hFF);
    stop_cond();
    check("wrap_final_addr_lit", reg_addr, 8'h01);
    check_drained("wrap");

    // Reset while the target holds SDA low for a read bit.
    start_cond();
    write_byte(8'h84, -1, 0, ack);
    write_byte(8'h80, -1, 0, ack);
    start_cond();
    write_byte(8'h85, -1, 0, ack);
    wait_cyc(10);
    check("rst_mid_driving", sda_oe, 1'b1);
    ICE_RST = 1'b1;
    wait_cyc(1);
    check("rst_mid_released", sda_oe, 1'b0);
    check("rst_mid_addr", reg_addr, 8'h00);
    ICE_RST    = 1'b0;
    model_ptr  = 8'h00;
    model_busy = 1'b0;
    phase      = P_IDLE;
    for (int i = 0; i < 9; i++) begin
      clock_bit(1'b1, 0, r);
      check("post_rst_bus_free", r, 1'b1);
    end
    stop_cond();
    start_cond();
    write_byte(8'h84, -1, 0, ack); check("post_rst_addr_ack_lit", ack, 1'b0);
    write_byte(8'h05, -1, 0, ack);
    write_byte(8'h33, -1, 0, ack);
    stop_cond();
    check("post_rst_final_addr_lit", reg_addr, 8'h06);
    check_drained("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
